// File: rtl/usr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// usr_ctrl_pkg
// Shared definitions for the USR transfer controller:
//   - USR mode codes driven onto the shift register's Mode_In
//   - FSM state encoding of the controller
//   - bit_reverse helper used for MSB-first framing
// ---------------------------------------------------------------------------
package usr_ctrl_pkg;

    // USR mode codes
    localparam logic [1:0] NO_CHANGE     = 2'b00;
    localparam logic [1:0] SHIFT_RIGHT   = 2'b01;
    localparam logic [1:0] SHIFT_LEFT    = 2'b10;
    localparam logic [1:0] LOAD_PARALLEL = 2'b11;

    // Controller FSM state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_SHIFT   = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_GAP     = 3'd4;

    // Reverse the low w bits of d (w in 1..8); bits at and above w return 0.
    function automatic logic [7:0] bit_reverse(input logic [7:0] d, input int w);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < w) begin
                r[i] = d[3'(w - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/usr_transfer_controller.sv
// ---------------------------------------------------------------------------
// usr_transfer_controller
// Sequences an attached universal shift register (USR) as a full-duplex word
// serializer/deserializer: parallel load, WIDTH right shifts, then hold and
// capture of the word that was shifted in.
//
// Parameters
//   WIDTH       shift length, equal to the attached USR width (2..8)
//   GAP_CYCLES  idle cycles after each word before Tx_Ready_Out returns (0..15)
//
// Ports
//   Clk_In                 in   clock, all state on posedge
//   Reset_N_In             in   asynchronous active-low reset
//   Tx_Valid_In            in   client word valid
//   Tx_Ready_Out           out  controller can accept a word (IDLE)
//   Tx_Data_In             in   word to transmit
//   Tx_Msb_First_In        in   bit order, sampled with the handshake
//   Rx_Valid_Out           out  one-cycle pulse, Rx_Data_Out valid
//   Rx_Data_Out            out  received word in the TX bit order
//   Busy_Out               out  high in every state except IDLE
//   Usr_Mode_Out           out  USR mode: 00 hold, 01 right, 11 load
//   Usr_Parallel_Data_Out  out  USR parallel load data
//   Usr_Parallel_Data_In   in   USR parallel contents
//   Abort_In               in   only with USR_CTRL_ABORT_EN defined: cancels
//                               a word in LOAD or SHIFT
//
// Build option: define USR_CTRL_ABORT_EN to add the Abort_In port.
//
// The USR updates on negedge, so every registered mode output set here on a
// posedge is applied by the USR half a cycle later. The USR serial out is
// bit0, so only right shifts are used; MSB-first framing is done by
// reversing the word on load and reversing the captured word.
// ---------------------------------------------------------------------------
module usr_transfer_controller
    import usr_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic             Clk_In,
    input  logic             Reset_N_In,
    input  logic             Tx_Valid_In,
    output logic             Tx_Ready_Out,
    input  logic [WIDTH-1:0] Tx_Data_In,
    input  logic             Tx_Msb_First_In,
    output logic             Rx_Valid_Out,
    output logic [WIDTH-1:0] Rx_Data_Out,
    output logic             Busy_Out,
    output logic [1:0]       Usr_Mode_Out,
    output logic [WIDTH-1:0] Usr_Parallel_Data_Out,
    input  logic [WIDTH-1:0] Usr_Parallel_Data_In
`ifdef USR_CTRL_ABORT_EN
    ,
    input  logic             Abort_In
`endif
);

    localparam logic [3:0] BIT_LAST = 4'(WIDTH - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    logic [2:0]       state_reg,    state_next;
    logic [3:0]       bit_cnt_reg,  bit_cnt_next;
    logic [3:0]       gap_cnt_reg,  gap_cnt_next;
    logic             msb_reg,      msb_next;
    logic             tx_ready_reg, tx_ready_next;
    logic             busy_reg,     busy_next;
    logic [1:0]       mode_reg,     mode_next;
    logic [WIDTH-1:0] pdata_reg,    pdata_next;
    logic             rx_valid_reg, rx_valid_next;
    logic [WIDTH-1:0] rx_data_reg,  rx_data_next;

    logic             abort_req;
    logic [7:0]       tx_rev8;
    logic [7:0]       rx_rev8;
    logic [WIDTH-1:0] tx_word;
    logic [WIDTH-1:0] rx_word;

`ifdef USR_CTRL_ABORT_EN
    assign abort_req = Abort_In;
`else
    assign abort_req = 1'b0;
`endif

    assign tx_rev8 = bit_reverse(8'(Tx_Data_In), WIDTH);
    assign rx_rev8 = bit_reverse(8'(Usr_Parallel_Data_In), WIDTH);
    assign tx_word = Tx_Msb_First_In ? tx_rev8[WIDTH-1:0] : Tx_Data_In;
    // Order for the RX word comes from the latched flag, not the live input.
    assign rx_word = msb_reg ? rx_rev8[WIDTH-1:0] : Usr_Parallel_Data_In;

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        msb_next      = msb_reg;
        tx_ready_next = tx_ready_reg;
        busy_next     = busy_reg;
        mode_next     = mode_reg;
        pdata_next    = pdata_reg;
        rx_valid_next = 1'b0;
        rx_data_next  = rx_data_reg;

        case (state_reg)
            ST_IDLE: begin
                if (Tx_Valid_In && tx_ready_reg) begin
                    state_next    = ST_LOAD;
                    msb_next      = Tx_Msb_First_In;
                    pdata_next    = tx_word;
                    mode_next     = LOAD_PARALLEL;
                    tx_ready_next = 1'b0;
                    busy_next     = 1'b1;
                end
            end

            ST_LOAD: begin
                if (abort_req) begin
                    state_next    = ST_IDLE;
                    mode_next     = NO_CHANGE;
                    tx_ready_next = 1'b1;
                    busy_next     = 1'b0;
                end else begin
                    state_next   = ST_SHIFT;
                    mode_next    = SHIFT_RIGHT;
                    bit_cnt_next = '0;
                end
            end

            ST_SHIFT: begin
                if (abort_req) begin
                    state_next    = ST_IDLE;
                    mode_next     = NO_CHANGE;
                    tx_ready_next = 1'b1;
                    busy_next     = 1'b0;
                end else if (bit_cnt_reg == BIT_LAST) begin
                    // WIDTH shift cycles done; hold so the USR is stable
                    // across the capture edge.
                    state_next = ST_CAPTURE;
                    mode_next  = NO_CHANGE;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                end
            end

            ST_CAPTURE: begin
                rx_data_next  = rx_word;
                rx_valid_next = 1'b1;
                mode_next     = NO_CHANGE;
                if (GAP_CYCLES > 0) begin
                    state_next   = ST_GAP;
                    gap_cnt_next = '0;
                end else begin
                    state_next    = ST_IDLE;
                    tx_ready_next = 1'b1;
                    busy_next     = 1'b0;
                end
            end

            ST_GAP: begin
                mode_next = NO_CHANGE;
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next    = ST_IDLE;
                    tx_ready_next = 1'b1;
                    busy_next     = 1'b0;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 4'd1;
                end
            end

            default: begin
                state_next    = ST_IDLE;
                mode_next     = NO_CHANGE;
                tx_ready_next = 1'b1;
                busy_next     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= '0;
            gap_cnt_reg  <= '0;
            msb_reg      <= 1'b0;
            tx_ready_reg <= 1'b1;
            busy_reg     <= 1'b0;
            mode_reg     <= NO_CHANGE;
            pdata_reg    <= '0;
            rx_valid_reg <= 1'b0;
            rx_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
            msb_reg      <= msb_next;
            tx_ready_reg <= tx_ready_next;
            busy_reg     <= busy_next;
            mode_reg     <= mode_next;
            pdata_reg    <= pdata_next;
            rx_valid_reg <= rx_valid_next;
            rx_data_reg  <= rx_data_next;
        end
    end

    assign Tx_Ready_Out          = tx_ready_reg;
    assign Busy_Out              = busy_reg;
    assign Usr_Mode_Out          = mode_reg;
    assign Usr_Parallel_Data_Out = pdata_reg;
    assign Rx_Valid_Out          = rx_valid_reg;
    assign Rx_Data_Out           = rx_data_reg;

endmodule

// File: tb/tb_usr_transfer_controller.sv
// ---------------------------------------------------------------------------
// tb_usr_transfer_controller
// Directed bench: two controllers (GAP_CYCLES=0 and GAP_CYCLES=3), each with
// a behavioural 8-bit USR that updates on negedge. Cycle numbering: the
// handshake edge is E0; "cyc n" means 1 ns after edge E0+n-1, i.e. inside
// cycle E0+n.
// ---------------------------------------------------------------------------
module tb_usr_transfer_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_msb;
    logic       tx_ready, rx_valid, busy;
    logic [7:0] rx_data, pout;
    logic [1:0] mode;
    logic [7:0] usr_q = 8'h00;
    logic       sl_loop, sl_drv, sl_in;

    logic       g_valid;
    logic [7:0] g_data;
    logic       g_ready, g_rx_valid, g_busy;
    logic [7:0] g_rx_data, g_pout;
    logic [1:0] g_mode;
    logic [7:0] g_usr_q = 8'h00;

`ifdef USR_CTRL_ABORT_EN
    logic abort;
`endif

    usr_transfer_controller #(.WIDTH(8), .GAP_CYCLES(0)) dut (
        .Clk_In                (clk),
        .Reset_N_In            (rst_n),
        .Tx_Valid_In           (tx_valid),
        .Tx_Ready_Out          (tx_ready),
        .Tx_Data_In            (tx_data),
        .Tx_Msb_First_In       (tx_msb),
        .Rx_Valid_Out          (rx_valid),
        .Rx_Data_Out           (rx_data),
        .Busy_Out              (busy),
        .Usr_Mode_Out          (mode),
        .Usr_Parallel_Data_Out (pout),
        .Usr_Parallel_Data_In  (usr_q)
`ifdef USR_CTRL_ABORT_EN
        ,
        .Abort_In              (abort)
`endif
    );

    usr_transfer_controller #(.WIDTH(8), .GAP_CYCLES(3)) dut_gap (
        .Clk_In                (clk),
        .Reset_N_In            (rst_n),
        .Tx_Valid_In           (g_valid),
        .Tx_Ready_Out          (g_ready),
        .Tx_Data_In            (g_data),
        .Tx_Msb_First_In       (1'b0),
        .Rx_Valid_Out          (g_rx_valid),
        .Rx_Data_Out           (g_rx_data),
        .Busy_Out              (g_busy),
        .Usr_Mode_Out          (g_mode),
        .Usr_Parallel_Data_Out (g_pout),
        .Usr_Parallel_Data_In  (g_usr_q)
`ifdef USR_CTRL_ABORT_EN
        ,
        .Abort_In              (abort)
`endif
    );

    // Behavioural USR: serial out = bit0, serial-left input enters bit7.
    assign sl_in = sl_loop ? usr_q[0] : sl_drv;

    always @(negedge clk) begin
        case (mode)
            2'b11:   usr_q <= pout;
            2'b01:   usr_q <= {sl_in, usr_q[7:1]};
            2'b10:   usr_q <= {usr_q[6:0], 1'b0};
            default: usr_q <= usr_q;
        endcase
    end

    always @(negedge clk) begin
        case (g_mode)
            2'b11:   g_usr_q <= g_pout;
            2'b01:   g_usr_q <= {g_usr_q[0], g_usr_q[7:1]};
            2'b10:   g_usr_q <= {g_usr_q[6:0], 1'b0};
            default: g_usr_q <= g_usr_q;
        endcase
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Handshake on the main controller; returns in cyc 1 (LOAD).
    task automatic start_word(input logic [7:0] d, input logic msb);
        check_vec("ready_before_hs", 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_msb   = msb;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    bit s1_out [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    bit s2_in  [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    bit s2_out [8] = '{1, 0, 0, 0, 0, 0, 0, 1};

    int pulses;

    initial begin
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_msb   = 1'b0;
        g_valid  = 1'b0;
        g_data   = 8'h00;
        sl_loop  = 1'b1;
        sl_drv   = 1'b0;
`ifdef USR_CTRL_ABORT_EN
        abort    = 1'b0;
`endif

        // ---- reset state ----
        #2 rst_n = 1'b0;
        #1;
        check_vec("rst_ready", 32'(tx_ready), 32'd1);
        check_vec("rst_busy",  32'(busy),     32'd0);
        check_vec("rst_mode",  32'(mode),     32'd0);
        check_vec("rst_rxv",   32'(rx_valid), 32'd0);
        check_vec("rst_rxd",   32'(rx_data),  32'd0);
        check_vec("rst_pdata", 32'(pout),     32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_vec("idle_ready", 32'(tx_ready), 32'd1);
        check_vec("idle_mode",  32'(mode),     32'd0);

        // ---- 1: LSB-first 0xA5, loopback ----
        start_word(8'hA5, 1'b0);
        check_vec("t1_load_mode",  32'(mode),     32'd3);
        check_vec("t1_load_pdata", 32'(pout),     32'hA5);
        check_vec("t1_load_ready", 32'(tx_ready), 32'd0);
        check_vec("t1_load_busy",  32'(busy),     32'd1);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_vec($sformatf("t1_shift_mode%0d", k), 32'(mode), 32'd1);
            check_vec($sformatf("t1_sout%0d", k), 32'(usr_q[0]), 32'(s1_out[k]));
        end
        tick(); // cyc 10: CAPTURE
        check_vec("t1_cap_mode",  32'(mode),     32'd0);
        check_vec("t1_cap_ready", 32'(tx_ready), 32'd0);
        check_vec("t1_cap_rxv",   32'(rx_valid), 32'd0);
        tick(); // cyc 11
        check_vec("t1_rxv",   32'(rx_valid), 32'd1);
        check_vec("t1_rxd",   32'(rx_data),  32'hA5);
        check_vec("t1_ready", 32'(tx_ready), 32'd1);
        check_vec("t1_busy",  32'(busy),     32'd0);
        $display("xfer t1 lsb tx=a5 rx=%h", rx_data);
        tick();
        check_vec("t1_rxv_pulse", 32'(rx_valid), 32'd0);
        check_vec("t1_rxd_hold",  32'(rx_data),  32'hA5);

        // ---- 2: MSB-first 0x81, driven serial-left input ----
        sl_loop = 1'b0;
        start_word(8'h81, 1'b1);
        check_vec("t2_load_pdata", 32'(pout), 32'h81);
        for (int k = 0; k < 8; k++) begin
            tick();
            sl_drv = s2_in[k];
            check_vec($sformatf("t2_sout%0d", k), 32'(usr_q[0]), 32'(s2_out[k]));
        end
        tick();
        tick();
        check_vec("t2_rxv", 32'(rx_valid), 32'd1);
        check_vec("t2_rxd", 32'(rx_data),  32'hC0);
        $display("xfer t2 msb tx=81 rx=%h", rx_data);
        sl_loop = 1'b1;

        // ---- 2b: MSB-first 0x12 loopback (load is reversed) ----
        tick();
        start_word(8'h12, 1'b1);
        check_vec("t2b_load_pdata", 32'(pout), 32'h48);
        repeat (10) tick();
        check_vec("t2b_rxv", 32'(rx_valid), 32'd1);
        check_vec("t2b_rxd", 32'(rx_data),  32'h12);
        $display("xfer t2b msb tx=12 rx=%h", rx_data);

        // ---- 3: back-to-back with valid held high ----
        tick();
        check_vec("t3_ready_before", 32'(tx_ready), 32'd1);
        tx_data  = 8'h01;
        tx_msb   = 1'b0;
        tx_valid = 1'b1;
        tick(); // E0 handshake, cyc 1
        tx_data = 8'h02;
        check_vec("t3_w1_pdata", 32'(pout), 32'h01);
        repeat (9) tick(); // cyc 10
        check_vec("t3_cap_ready", 32'(tx_ready), 32'd0);
        check_vec("t3_cap_mode",  32'(mode),     32'd0);
        tick(); // cyc 11
        check_vec("t3_w1_rxv",     32'(rx_valid), 32'd1);
        check_vec("t3_w1_rxd",     32'(rx_data),  32'h01);
        check_vec("t3_overlap_rdy", 32'(tx_ready), 32'd1);
        $display("xfer t3a tx=01 rx=%h", rx_data);
        tick(); // second handshake 11 cycles after the first
        tx_valid = 1'b0;
        check_vec("t3_w2_mode",  32'(mode), 32'd3);
        check_vec("t3_w2_pdata", 32'(pout), 32'h02);
        repeat (10) tick();
        check_vec("t3_w2_rxv", 32'(rx_valid), 32'd1);
        check_vec("t3_w2_rxd", 32'(rx_data),  32'h02);
        $display("xfer t3b tx=02 rx=%h", rx_data);

        // ---- 4: GAP_CYCLES=3 instance ----
        tick();
        check_vec("t4_ready_before", 32'(g_ready), 32'd1);
        g_data  = 8'h6B;
        g_valid = 1'b1;
        tick();
        g_valid = 1'b0;
        check_vec("t4_load_busy", 32'(g_busy), 32'd1);
        repeat (10) tick(); // cyc 11
        check_vec("t4_rxv",       32'(g_rx_valid), 32'd1);
        check_vec("t4_rxd",       32'(g_rx_data),  32'h6B);
        check_vec("t4_rx_ready",  32'(g_ready),    32'd0);
        check_vec("t4_rx_busy",   32'(g_busy),     32'd1);
        $display("xfer t4 gap tx=6b rx=%h", g_rx_data);
        tick(); // cyc 12
        check_vec("t4_g12_ready", 32'(g_ready),    32'd0);
        check_vec("t4_g12_busy",  32'(g_busy),     32'd1);
        check_vec("t4_g12_mode",  32'(g_mode),     32'd0);
        check_vec("t4_g12_rxv",   32'(g_rx_valid), 32'd0);
        tick(); // cyc 13
        check_vec("t4_g13_ready", 32'(g_ready), 32'd0);
        check_vec("t4_g13_busy",  32'(g_busy),  32'd1);
        tick(); // cyc 14
        check_vec("t4_g14_ready", 32'(g_ready), 32'd1);
        check_vec("t4_g14_busy",  32'(g_busy),  32'd0);

        // ---- 5: reset during SHIFT cycle 4 ----
        tick();
        start_word(8'h5A, 1'b0);
        repeat (4) tick(); // cyc 5: SHIFT cycle 4
        check_vec("t5_pre_mode", 32'(mode), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_vec("t5_rst_ready", 32'(tx_ready), 32'd1);
        check_vec("t5_rst_busy",  32'(busy),     32'd0);
        check_vec("t5_rst_mode",  32'(mode),     32'd0);
        check_vec("t5_rst_rxv",   32'(rx_valid), 32'd0);
        check_vec("t5_rst_rxd",   32'(rx_data),  32'd0);
        check_vec("t5_rst_pdata", 32'(pout),     32'd0);
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (rx_valid) pulses++;
        end
        check_vec("t5_no_pulse", 32'(pulses), 32'd0);
        start_word(8'h3C, 1'b0);
        repeat (10) tick();
        check_vec("t5_rxv", 32'(rx_valid), 32'd1);
        check_vec("t5_rxd", 32'(rx_data),  32'h3C);
        $display("xfer t5 after reset tx=3c rx=%h", rx_data);

`ifdef USR_CTRL_ABORT_EN
        // ---- 6: abort in SHIFT cycle 2 ----
        tick();
        start_word(8'h77, 1'b0);
        tick(); // cyc 2: SHIFT cycle 1
        tick(); // cyc 3: SHIFT cycle 2
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_vec("t6_mode",  32'(mode),     32'd0);
        check_vec("t6_ready", 32'(tx_ready), 32'd1);
        check_vec("t6_busy",  32'(busy),     32'd0);
        check_vec("t6_rxv",   32'(rx_valid), 32'd0);
        check_vec("t6_rxd",   32'(rx_data),  32'h3C);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (rx_valid) pulses++;
        end
        check_vec("t6_no_pulse", 32'(pulses), 32'd0);
        check_vec("t6_rxd_hold", 32'(rx_data), 32'h3C);
        $display("xfer t6 aborted tx=77 rx=%h", rx_data);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
